alu_req_scheduler: RTL and testbench
====================================

// Module: alu_req_scheduler
// PURPOSE
//  Shares one ALU instance among NUM_REQ requesters. Grants the ALU to one requester at a time,
//  drives the ALU input pins, waits the command-dependent ALU latency, captures RES/flags,
//  and returns them on a single tagged response channel. Sits between the requester agents
//  and the ALU pins (CE, MODE, CMD, INP_VALID, OPA, OPB, CIN -> RES, ERR, OFLOW, COUT, G, L, E).
// PARAMETERS
//  WIDTH      8  operand width; RES is WIDTH+2 bits
//  CMD_WIDTH  3  CMD is CMD_WIDTH+1 bits
//  NUM_REQ    4  number of requesters (2..8)
//  ALU_LAT    1  cycles from issue edge to valid RES, for all commands except multiply
//  MUL_LAT    2  same, for MODE=1 and CMD in {9,10}
// PORTS
//  clk            in   1                   clock, all logic on posedge
//  RST            in   1                   asynchronous active-low reset
//  req_valid      in   NUM_REQ             per-requester op valid; held until req_ready
//  req_ready      out  NUM_REQ             one-hot accept pulse, 1 cycle
//  req_mode       in   NUM_REQ             per-requester MODE
//  req_cmd        in   NUM_REQ*(CMD_WIDTH+1) per-requester CMD, packed, requester 0 in LSBs
//  req_inp_valid  in   NUM_REQ*2           per-requester INP_VALID
//  req_opa/opb    in   NUM_REQ*WIDTH       per-requester operands
//  req_cin        in   NUM_REQ             per-requester CIN
//  alu_ce, alu_mode, alu_cin  out 1        to ALU
//  alu_cmd        out  CMD_WIDTH+1         to ALU
//  alu_inp_valid  out  2                   to ALU
//  alu_opa/opb    out  WIDTH               to ALU
//  alu_res        in   WIDTH+2             from ALU
//  alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e  in 1  from ALU
//  rsp_valid      out  1                   response valid; held until rsp_ready
//  rsp_ready      in   1                   response accept
//  rsp_id         out  clog2(NUM_REQ)      requester index of this response
//  rsp_res        out  WIDTH+2             captured RES
//  rsp_flags      out  6                   {ERR,OFLOW,COUT,G,L,E}
// BEHAVIOUR
//  Reset (RST=0, async): state IDLE, rr pointer 0, every output 0, in-flight op dropped.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: no req_valid -> stay. Otherwise grant one requester, pulse its req_ready, latch its
//         bundle and id -> ISSUE. Only one req_ready bit may be high in any cycle.
//   ISSUE: drive latched bundle on alu_* with alu_ce=1. Load wait counter with MUL_LAT when
//          mode=1 and cmd in {9,10}, else ALU_LAT -> WAIT.
//   WAIT: hold alu_* and alu_ce=1 stable; decrement counter. At 1, capture alu_res/flags
//         into rsp_* on that edge -> RESP.
//   RESP: rsp_valid=1, rsp_* stable; rsp_ready=1 -> IDLE (rsp_valid low next cycle).
//  alu_ce=0 and alu_* inputs=0 in IDLE and RESP.
//  Issue-to-response latency: 1 + LAT cycles. Op-to-op spacing with rsp_ready tied high: LAT+3.
//  INP_VALID=2'b00 ops are forwarded unchanged; ERR is reported in rsp_flags, not filtered.
//  A req_valid that rises while RESP waits is not granted until IDLE. No bypass.
//  Grant, round-robin: first valid at or after ptr, wrapping NUM_REQ-1 -> 0; ptr <= grant+1 mod NUM_REQ.
//  A requester dropping req_valid before ready is not required to work; the grant uses the current cycle only.
// CONFIGURATION
//  ALU_SCHED_FIXED_PRI_EN defined: fixed priority, lowest index wins; rr pointer removed.
//  Not defined (default): round-robin as above.
// STRUCTURE
//  alu_sched_pkg: state enum {IDLE,ISSUE,WAIT,RESP}; CMD_MUL_INC=9, CMD_MUL_SHL=10 constants;
//  flags struct {err,oflow,cout,g,l,e}; lat counter width function.
//  Sub-module alu_rr_arbiter: req vector + ptr -> one-hot grant + index (combinational),
//  holds the macro switch.
// TESTING
//  1. Single req0 ADD (MODE=1,CMD=0,OPA=8'h05,OPB=8'h03,INP_VALID=3) -> rsp_id=0, rsp_res=8, 1+ALU_LAT cycles after ISSUE.
//  2. MODE=1 CMD=9 OPA=3 OPB=4 -> alu_ce held MUL_LAT+1 cycles; rsp_res=(4*5)=20.
//  3. All 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0; fixed-pri build -> 0,0,0.
//  4. rsp_ready low 5 cycles -> rsp_* stable, no req_ready, no alu_ce during stall.
//  5. RST low during WAIT -> all outputs 0 asynchronously; after release, pending req regranted from ptr 0.
//  6. INP_VALID=0 op -> forwarded; rsp_flags[5] (ERR) mirrors alu_err.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU request scheduler.
package alu_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam int unsigned CMD_MUL_INC = 9;
  localparam int unsigned CMD_MUL_SHL = 10;

  typedef struct packed {
    logic err;
    logic oflow;
    logic cout;
    logic g;
    logic l;
    logic e;
  } flags_t;

  // Bits needed to hold a latency value up to max_lat.
  function automatic int unsigned lat_cnt_w(input int unsigned max_lat);
    return (max_lat < 2) ? 1 : $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Combinational requester arbiter: round-robin from ptr by default,
// lowest-index fixed priority when ALU_SCHED_FIXED_PRI_EN is defined.
module alu_rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef ALU_SCHED_FIXED_PRI_EN
  input  logic [IDW-1:0]     ptr,
`endif
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDW-1:0]     gnt_idx_c,
  output logic               any_c
);

`ifdef ALU_SCHED_FIXED_PRI_EN
  always_comb begin
    gnt_idx_c = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (req[k]) gnt_idx_c = IDW'(k);
    end
  end
`else
  int unsigned idx;
  logic        found;

  // First valid requester at or after ptr, wrapping to 0.
  always_comb begin
    gnt_idx_c = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        gnt_idx_c = IDW'(idx);
      end
    end
  end
`endif

  assign any_c = |req;
  assign gnt_c = any_c ? (NUM_REQ'(1) << gnt_idx_c) : '0;

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU among NUM_REQ requesters with a tagged response channel.
// Build option: define ALU_SCHED_FIXED_PRI_EN for fixed lowest-index priority.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CMD_WIDTH = 3,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ALU_LAT   = 1,
  parameter int unsigned MUL_LAT   = 2
) (
  input  logic                             clk,
  input  logic                             RST,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_mode,
  input  logic [NUM_REQ*(CMD_WIDTH+1)-1:0] req_cmd,
  input  logic [NUM_REQ*2-1:0]             req_inp_valid,
  input  logic [NUM_REQ*WIDTH-1:0]         req_opa,
  input  logic [NUM_REQ*WIDTH-1:0]         req_opb,
  input  logic [NUM_REQ-1:0]               req_cin,
  output logic                             alu_ce,
  output logic                             alu_mode,
  output logic                             alu_cin,
  output logic [CMD_WIDTH:0]               alu_cmd,
  output logic [1:0]                       alu_inp_valid,
  output logic [WIDTH-1:0]                 alu_opa,
  output logic [WIDTH-1:0]                 alu_opb,
  input  logic [WIDTH+1:0]                 alu_res,
  input  logic                             alu_err,
  input  logic                             alu_oflow,
  input  logic                             alu_cout,
  input  logic                             alu_g,
  input  logic                             alu_l,
  input  logic                             alu_e,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
  output logic [WIDTH+1:0]                 rsp_res,
  output logic [5:0]                       rsp_flags
);

  localparam int unsigned CW  = CMD_WIDTH + 1;
  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned LCW = lat_cnt_w((ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT);

  state_e             state_q, state_d;
  logic [LCW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0] req_ready_d;
  logic               alu_ce_d, alu_mode_d, alu_cin_d;
  logic [CW-1:0]      alu_cmd_d;
  logic [1:0]         alu_inp_valid_d;
  logic [WIDTH-1:0]   alu_opa_d, alu_opb_d;
  logic               rsp_valid_d;
  logic [IDW-1:0]     rsp_id_d;
  logic [WIDTH+1:0]   rsp_res_d;
  logic [5:0]         rsp_flags_d;
  logic [NUM_REQ-1:0] gnt_c;
  logic [IDW-1:0]     gnt_idx_c;
  logic               any_c;
  logic               is_mul_c;
  flags_t             cap_c;

  logic [CW-1:0]    cmd_a [NUM_REQ];
  logic [1:0]       iv_a  [NUM_REQ];
  logic [WIDTH-1:0] opa_a [NUM_REQ];
  logic [WIDTH-1:0] opb_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign cmd_a[i] = req_cmd[i*CW +: CW];
    assign iv_a[i]  = req_inp_valid[i*2 +: 2];
    assign opa_a[i] = req_opa[i*WIDTH +: WIDTH];
    assign opb_a[i] = req_opb[i*WIDTH +: WIDTH];
  end

`ifndef ALU_SCHED_FIXED_PRI_EN
  logic [IDW-1:0] ptr_q, ptr_d;
`endif

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
`ifndef ALU_SCHED_FIXED_PRI_EN
    .ptr       (ptr_q),
`endif
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .any_c     (any_c)
  );

  assign is_mul_c = alu_mode && ((alu_cmd == CW'(CMD_MUL_INC)) || (alu_cmd == CW'(CMD_MUL_SHL)));
  assign cap_c    = {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};

  // Next-state and next-output logic; the latched bundle lives in the alu_* registers.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    req_ready_d     = '0;
    alu_ce_d        = alu_ce;
    alu_mode_d      = alu_mode;
    alu_cin_d       = alu_cin;
    alu_cmd_d       = alu_cmd;
    alu_inp_valid_d = alu_inp_valid;
    alu_opa_d       = alu_opa;
    alu_opb_d       = alu_opb;
    rsp_valid_d     = rsp_valid;
    rsp_id_d        = rsp_id;
    rsp_res_d       = rsp_res;
    rsp_flags_d     = rsp_flags;
`ifndef ALU_SCHED_FIXED_PRI_EN
    ptr_d           = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_c) begin
          req_ready_d     = gnt_c;
          alu_ce_d        = 1'b1;
          alu_mode_d      = req_mode[gnt_idx_c];
          alu_cin_d       = req_cin[gnt_idx_c];
          alu_cmd_d       = cmd_a[gnt_idx_c];
          alu_inp_valid_d = iv_a[gnt_idx_c];
          alu_opa_d       = opa_a[gnt_idx_c];
          alu_opb_d       = opb_a[gnt_idx_c];
          rsp_id_d        = gnt_idx_c;
`ifndef ALU_SCHED_FIXED_PRI_EN
          ptr_d           = (gnt_idx_c == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx_c + IDW'(1);
`endif
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = is_mul_c ? LCW'(MUL_LAT) : LCW'(ALU_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q <= LCW'(1)) begin
          rsp_valid_d     = 1'b1;
          rsp_res_d       = alu_res;
          rsp_flags_d     = cap_c;
          alu_ce_d        = 1'b0;
          alu_mode_d      = 1'b0;
          alu_cin_d       = 1'b0;
          alu_cmd_d       = '0;
          alu_inp_valid_d = '0;
          alu_opa_d       = '0;
          alu_opb_d       = '0;
          state_d         = RESP;
        end else begin
          cnt_d = cnt_q - LCW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_id_d    = '0;
          rsp_res_d   = '0;
          rsp_flags_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_ready     <= '0;
      alu_ce        <= 1'b0;
      alu_mode      <= 1'b0;
      alu_cin       <= 1'b0;
      alu_cmd       <= '0;
      alu_inp_valid <= '0;
      alu_opa       <= '0;
      alu_opb       <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_res       <= '0;
      rsp_flags     <= '0;
`ifndef ALU_SCHED_FIXED_PRI_EN
      ptr_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready     <= req_ready_d;
      alu_ce        <= alu_ce_d;
      alu_mode      <= alu_mode_d;
      alu_cin       <= alu_cin_d;
      alu_cmd       <= alu_cmd_d;
      alu_inp_valid <= alu_inp_valid_d;
      alu_opa       <= alu_opa_d;
      alu_opb       <= alu_opb_d;
      rsp_valid     <= rsp_valid_d;
      rsp_id        <= rsp_id_d;
      rsp_res       <= rsp_res_d;
      rsp_flags     <= rsp_flags_d;
`ifndef ALU_SCHED_FIXED_PRI_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler with a small pipelined ALU model.
module tb_alu_req_scheduler;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned CMD_WIDTH = 3;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned ALU_LAT   = 1;
  localparam int unsigned MUL_LAT   = 2;
  localparam int unsigned CW        = CMD_WIDTH + 1;
  localparam int unsigned RW        = WIDTH + 2;

  logic                     clk = 1'b0;
  logic                     RST = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_mode = '0;
  logic [NUM_REQ*CW-1:0]    req_cmd = '0;
  logic [NUM_REQ*2-1:0]     req_inp_valid = '0;
  logic [NUM_REQ*WIDTH-1:0] req_opa = '0;
  logic [NUM_REQ*WIDTH-1:0] req_opb = '0;
  logic [NUM_REQ-1:0]       req_cin = '0;
  logic                     alu_ce, alu_mode, alu_cin;
  logic [CW-1:0]            alu_cmd;
  logic [1:0]               alu_inp_valid;
  logic [WIDTH-1:0]         alu_opa, alu_opb;
  logic [RW-1:0]            alu_res;
  logic                     alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b0;
  logic [1:0]               rsp_id;
  logic [RW-1:0]            rsp_res;
  logic [5:0]               rsp_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_req_scheduler #(
    .WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH), .NUM_REQ(NUM_REQ),
    .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_cmd(req_cmd), .req_inp_valid(req_inp_valid), .req_opa(req_opa),
    .req_opb(req_opb), .req_cin(req_cin),
    .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_cmd(alu_cmd),
    .alu_inp_valid(alu_inp_valid), .alu_opa(alu_opa), .alu_opb(alu_opb),
    .alu_res(alu_res), .alu_err(alu_err), .alu_oflow(alu_oflow), .alu_cout(alu_cout),
    .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags)
  );

  // ALU model: {flags, res}; multiplies need two pipeline stages, everything else one.
  function automatic logic [RW+5:0] alu_f(input logic [CW-1:0] c, input logic [1:0] iv,
                                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [RW-1:0] r;
    logic [5:0]    f;
    if (iv != 2'b11) begin
      r = '0;
      f = 6'b100000;
    end else begin
      case (c)
        4'd0:    r = RW'(a) + RW'(b);
        4'd1:    r = RW'(a) - RW'(b);
        4'd9:    r = (RW'(a) + RW'(1)) * (RW'(b) + RW'(1));
        4'd10:   r = (RW'(a) << 1) * RW'(b);
        default: r = '0;
      endcase
      f = {1'b0, 1'b0, r[WIDTH], a > b, a < b, a == b};
    end
    return {f, r};
  endfunction

  logic [RW+5:0] s1 = '0;
  logic [RW+5:0] s2 = '0;
  always @(posedge clk) begin
    s1 <= alu_ce ? alu_f(alu_cmd, alu_inp_valid, alu_opa, alu_opb) : '0;
    s2 <= s1;
  end
  assign {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_res} =
    (alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10)) ? s2 : s1;

  task automatic set_req(input int i, input logic m, input logic [CW-1:0] c,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] iv);
    req_mode[i]                = m;
    req_cmd[i*CW +: CW]        = c;
    req_opa[i*WIDTH +: WIDTH]  = a;
    req_opb[i*WIDTH +: WIDTH]  = b;
    req_inp_valid[i*2 +: 2]    = iv;
    req_cin[i]                 = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (n) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 RST = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    checks++;
    if ({alu_ce, alu_mode, alu_cin, alu_cmd, alu_inp_valid, alu_opa, alu_opb} !== '0) begin
      errors++; $display("FAIL reset_alu_pins got ce=%b opa=%h want all 0", alu_ce, alu_opa);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_res, rsp_flags} !== '0) begin
      errors++; $display("FAIL reset_rsp got valid=%b res=%h want all 0", rsp_valid, rsp_res);
    end
    RST = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    int n;
    int lat;
    set_req(0, 1'b1, 4'd0, 8'h05, 8'h03, 2'b11);
    req_valid = 4'b0001;
    n = 0;
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL add_grant got %b want 0001", req_ready); end
    checks++;
    if ({alu_ce, alu_mode, alu_cmd, alu_opa, alu_opb} !== {1'b1, 1'b1, 4'd0, 8'h05, 8'h03}) begin
      errors++; $display("FAIL add_issue_pins got ce=%b cmd=%0d opa=%h opb=%h want 1 0 05 03",
                         alu_ce, alu_cmd, alu_opa, alu_opb);
    end
    req_valid = '0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if (lat != 1 + ALU_LAT) begin errors++; $display("FAIL add_latency got %0d want %0d", lat, 1 + ALU_LAT); end
    checks++;
    if ({rsp_id, rsp_res, rsp_flags} !== {2'd0, 10'd8, 6'b000100}) begin
      errors++; $display("FAIL add_rsp got id=%0d res=%0d flags=%b want 0 8 000100", rsp_id, rsp_res, rsp_flags);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, alu_ce, alu_opa, alu_opb} !== '0) begin
      errors++; $display("FAIL add_idle_after got rsp_valid=%b ce=%b opa=%h want 0", rsp_valid, alu_ce, alu_opa);
    end
  endtask

  task automatic test_mul;
    int n;
    int ce_cnt;
    set_req(2, 1'b1, 4'd9, 8'd3, 8'd4, 2'b11);
    req_valid = 4'b0100;
    n = 0;
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL mul_grant got %b want 0100", req_ready); end
    req_valid = '0;
    ce_cnt = 0;
    while (alu_ce === 1'b1 && ce_cnt < 20) begin ce_cnt++; @(negedge clk); end
    checks++;
    if (ce_cnt != MUL_LAT + 1) begin errors++; $display("FAIL mul_ce_cycles got %0d want %0d", ce_cnt, MUL_LAT + 1); end
    checks++;
    if ({rsp_valid, rsp_id, rsp_res, rsp_flags} !== {1'b1, 2'd2, 10'd20, 6'b000010}) begin
      errors++; $display("FAIL mul_rsp got v=%b id=%0d res=%0d flags=%b want 1 2 20 000010",
                         rsp_valid, rsp_id, rsp_res, rsp_flags);
    end
    drain(3);
  endtask

  task automatic test_back_to_back;
    int exp_g [5];
`ifdef ALU_SCHED_FIXED_PRI_EN
    exp_g = '{0, 0, 0, 0, 0};
`else
    exp_g = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'd0, WIDTH'(i), 8'd1, 2'b11);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      int n;
      logic [NUM_REQ-1:0] want;
      @(negedge clk);
      n = 1;
      while (req_ready == '0 && n < 30) begin @(negedge clk); n++; end
      want = NUM_REQ'(1) << exp_g[g];
      checks++;
      if (req_ready !== want) begin errors++; $display("FAIL rr_grant%0d got %b want %b", g, req_ready, want); end
      if (g > 0) begin
        checks++;
        if (n != ALU_LAT + 3) begin errors++; $display("FAIL rr_spacing%0d got %0d want %0d", g, n, ALU_LAT + 3); end
      end
    end
    drain(8);
  endtask

  task automatic test_stall;
    int n;
    logic bad;
    do_reset();
    set_req(3, 1'b1, 4'd1, 8'd9, 8'd2, 2'b11);
    req_valid = 4'b1000;
    n = 0;
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    req_valid = '0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    set_req(0, 1'b1, 4'd0, 8'd1, 8'd1, 2'b11);
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      bad = (rsp_valid !== 1'b1) || (rsp_id !== 2'd3) || (rsp_res !== 10'd7) ||
            (rsp_flags !== 6'b000100) || (req_ready !== '0) || (alu_ce !== 1'b0);
      checks++;
      if (bad) begin
        errors++; $display("FAIL stall_cycle%0d got v=%b id=%0d res=%0d fl=%b rdy=%b ce=%b want 1 3 7 000100 0 0",
                           k, rsp_valid, rsp_id, rsp_res, rsp_flags, req_ready, alu_ce);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready} !== 5'b0) begin
      errors++; $display("FAIL stall_release got v=%b rdy=%b want 0 0000", rsp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_next_grant got %b want 0001", req_ready); end
    drain(8);
  endtask

  task automatic test_reset_wait;
    int n;
    do_reset();
    set_req(1, 1'b1, 4'd9, 8'd2, 8'd2, 2'b11);
    set_req(3, 1'b1, 4'd0, 8'd1, 8'd1, 2'b11);
    req_valid = 4'b1010;
    n = 0;
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL rstw_grant got %b want 0010", req_ready); end
    @(negedge clk);
    checks++;
    if (alu_ce !== 1'b1) begin errors++; $display("FAIL rstw_in_wait got ce=%b want 1", alu_ce); end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({req_ready, alu_ce, alu_mode, alu_cin, alu_cmd, alu_inp_valid, alu_opa, alu_opb,
         rsp_valid, rsp_id, rsp_res, rsp_flags} !== '0) begin
      errors++; $display("FAIL rstw_async_clear got ce=%b rdy=%b opa=%h v=%b want all 0",
                         alu_ce, req_ready, alu_opa, rsp_valid);
    end
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL rstw_regrant got %b want 0010", req_ready); end
    drain(10);
  endtask

  task automatic test_err;
    int n;
    do_reset();
    set_req(0, 1'b1, 4'd0, 8'd5, 8'd3, 2'b00);
    req_valid = 4'b0001;
    n = 0;
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if ({alu_ce, alu_inp_valid} !== 3'b100) begin
      errors++; $display("FAIL err_forward got ce=%b iv=%b want 1 00", alu_ce, alu_inp_valid);
    end
    req_valid = '0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if ({rsp_valid, rsp_res, rsp_flags} !== {1'b1, 10'd0, 6'b100000}) begin
      errors++; $display("FAIL err_rsp got v=%b res=%0d flags=%b want 1 0 100000", rsp_valid, rsp_res, rsp_flags);
    end
    drain(3);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_stall();
    test_reset_wait();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
